// File: rtl/miss_arb_pkg.sv
// Shared types and constants for the miss arbiter.
package miss_arb_pkg;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int BLOCK_OFF_W     = $clog2(WORDS_PER_BLOCK);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_FILL,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_e;

endpackage

// File: rtl/miss_arbiter_blk_addr_seq.sv
// Block fill address sequencer: issue/return counters, start offset and
// block address formation. With MISS_ARB_CRITICAL_WORD_FIRST_EN defined the
// sequence starts at the missed word and wraps inside the block; otherwise
// it always starts at word 0.
module blk_addr_seq #(
  parameter int  ADDR_W          = 16,
  parameter int  WORDS_PER_BLOCK = miss_arb_pkg::WORDS_PER_BLOCK,
  localparam int OFF_W           = $clog2(WORDS_PER_BLOCK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              fill_active,
  input  logic              rx_valid,
  output logic              issue_active,
  output logic [ADDR_W-1:0] issue_addr,
  output logic [OFF_W-1:0]  rx_off,
  output logic              rx_last
);

  // Byte bits covering one block of 16-bit words.
  localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(2 * WORDS_PER_BLOCK - 1);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [OFF_W-1:0]  start_q, start_d;
  logic [OFF_W:0]    issue_cnt_q, issue_cnt_d;
  logic [OFF_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [OFF_W-1:0]  issue_off;

  // Offsets add modulo the block size, so the wrap is free.
  assign issue_active = !issue_cnt_q[OFF_W];
  assign issue_off    = start_q + issue_cnt_q[OFF_W-1:0];
  assign issue_addr   = base_q | ADDR_W'({issue_off, 1'b0});
  assign rx_off       = start_q + rx_cnt_q;
  assign rx_last      = &rx_cnt_q;

  // Next-state for base, start offset and both counters.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    base_d      = base_q;
    start_d     = start_q;
    issue_cnt_d = issue_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    if (load) begin
      base_d      = miss_addr & ~BLK_MASK;
`ifdef MISS_ARB_CRITICAL_WORD_FIRST_EN
      start_d     = miss_addr[OFF_W:1];
`else
      start_d     = '0;
`endif
      issue_cnt_d = '0;
      rx_cnt_d    = '0;
    end else if (fill_active) begin
      if (issue_active) issue_cnt_d = issue_cnt_q + (OFF_W+1)'(1);
      if (rx_valid)     rx_cnt_d    = rx_cnt_q + OFF_W'(1);
    end
  end

  // Sequencer registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      base_q      <= '0;
      start_q     <= '0;
      issue_cnt_q <= '0;
      rx_cnt_q    <= '0;
    end else begin
      base_q      <= base_d;
      start_q     <= start_d;
      issue_cnt_q <= issue_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
    end
  end

endmodule

// File: rtl/miss_arbiter.sv
// Main-memory arbiter for I-cache fills, D-cache fills and D-cache
// write-through stores. Priority: store > D miss > I miss.
// Optional feature macro: MISS_ARB_CRITICAL_WORD_FIRST_EN (critical word first).
module miss_arbiter
  import miss_arb_pkg::*;
#(
  parameter int  ADDR_W          = 16,
  parameter int  DATA_W          = 16,
  parameter int  WORDS_PER_BLOCK = miss_arb_pkg::WORDS_PER_BLOCK,
  localparam int OFF_W           = $clog2(WORDS_PER_BLOCK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss_req,
  input  logic [ADDR_W-1:0] i_miss_addr,
  output logic              i_fill_we,
  output logic              i_fill_done,
  input  logic              d_miss_req,
  input  logic [ADDR_W-1:0] d_miss_addr,
  output logic              d_fill_we,
  output logic              d_fill_done,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              d_wr_ack,
  output logic [DATA_W-1:0] fill_data,
  output logic [OFF_W-1:0]  fill_word,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              busy
);

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic   wr_op_q, wr_op_d;

  logic              seq_load;
  logic [ADDR_W-1:0] seq_addr;
  logic              fill_active;
  logic              issue_active;
  logic [ADDR_W-1:0] issue_addr;
  logic [OFF_W-1:0]  rx_off;
  logic              rx_last;
  logic              rx_take;

  assign fill_active = (state_q == ST_FILL);
  assign rx_take     = fill_active && mem_valid;
  assign busy        = (state_q != ST_IDLE);

  blk_addr_seq #(
    .ADDR_W          (ADDR_W),
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK)
  ) u_seq (
    .clk          (clk),
    .rst          (rst),
    .load         (seq_load),
    .miss_addr    (seq_addr),
    .fill_active  (fill_active),
    .rx_valid     (mem_valid),
    .issue_active (issue_active),
    .issue_addr   (issue_addr),
    .rx_off       (rx_off),
    .rx_last      (rx_last)
  );

  // Next-state, grant and output decode.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wr_op_d     = wr_op_q;
    seq_load    = 1'b0;
    seq_addr    = d_miss_req ? d_miss_addr : i_miss_addr;
    i_fill_we   = 1'b0;
    i_fill_done = 1'b0;
    d_fill_we   = 1'b0;
    d_fill_done = 1'b0;
    d_wr_ack    = 1'b0;
    fill_data   = '0;
    fill_word   = '0;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (d_wr_req) begin
          state_d = ST_WRITE;
          owner_d = OWN_D;
          wr_op_d = 1'b1;
        end else if (d_miss_req || i_miss_req) begin
          state_d  = ST_FILL;
          owner_d  = d_miss_req ? OWN_D : OWN_I;
          wr_op_d  = 1'b0;
          seq_load = 1'b1;
        end
      end
      ST_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_wr_addr;
        mem_wdata = d_wr_data;
        state_d   = ST_DONE;
      end
      ST_FILL: begin
        if (issue_active) begin
          mem_en   = 1'b1;
          mem_addr = issue_addr;
        end
        if (rx_take) begin
          i_fill_we = (owner_q == OWN_I);
          d_fill_we = (owner_q == OWN_D);
          fill_data = mem_rdata;
          fill_word = rx_off;
          if (rx_last) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        d_wr_ack    = wr_op_q;
        d_fill_done = !wr_op_q && (owner_q == OWN_D);
        i_fill_done = !wr_op_q && (owner_q == OWN_I);
        owner_d     = OWN_NONE;
        wr_op_d     = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, owner and operation registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
      wr_op_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_op_q <= wr_op_d;
    end
  end

endmodule
